// File: rtl/layer_scheduler_pkg.sv
// Shared constants for the two-layer frame scheduler: state codes, layer select codes, image geometry.
package layer_scheduler_pkg;

    localparam int IMG_DIM = 64;
    localparam int PIX_CNT = IMG_DIM * IMG_DIM;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_L1_RUN   = 3'd1;
    localparam state_t ST_L1_DRAIN = 3'd2;
    localparam state_t ST_L2_RUN   = 3'd3;
    localparam state_t ST_DONE     = 3'd4;

    typedef logic [1:0] lsel_t;

    localparam lsel_t LSEL_NONE = 2'b00;
    localparam lsel_t LSEL_L1   = 2'b01;
    localparam lsel_t LSEL_L2   = 2'b10;

endpackage

// File: rtl/layer_scheduler_raster.sv
// 64x64 raster scan counter (x = column, y = row) with clear, advance and last-pixel flag.
module raster_counter
    import layer_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    output logic [5:0] x,
    output logic [5:0] y,
    output logic       last
);

    localparam logic [5:0] EDGE = 6'(IMG_DIM - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            x <= x + 6'd1;
            if (x == EDGE) begin
                y <= y + 6'd1;
            end
        end
    end

    assign last = (x == EDGE) && (y == EDGE);

endmodule

// File: rtl/layer_scheduler.sv
// Two-layer frame scheduler: Layer1 streams one window per cycle through an L1_LAT-deep pipeline,
// Layer2 spends FOLD cycles per pixel. Define LAYER_SCHED_PERF_EN to build the busy-cycle counter.
module layer_scheduler
    import layer_scheduler_pkg::*;
#(
    parameter int L1_LAT = 4,
    parameter int FOLD   = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [5:0]  win_x,
    output logic [5:0]  win_y,
    output logic [1:0]  layer_sel,
    output logic [3:0]  fold_cnt,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [19:0] perf_cycles
);

    localparam logic [3:0]  FOLD_LAST = 4'(FOLD - 1);
    localparam logic [11:0] WCNT_LAST = 12'(PIX_CNT - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [L1_LAT-1:0]  tok_reg;
    logic [11:0]        wcnt_reg;
    logic [3:0]         fold_reg;

    logic [5:0] ras_x;
    logic [5:0] ras_y;
    logic       ras_last;
    logic       ras_clear;
    logic       ras_advance;

    logic accept;
    logic l1_wr;
    logic l2_wr;
    logic l1_done;

    assign win_valid = (state_reg == ST_L1_RUN) ||
                       ((state_reg == ST_L2_RUN) && (fold_reg == 4'd0));
    assign accept    = win_valid && win_ready;
    assign l1_wr     = tok_reg[L1_LAT-1];
    assign l2_wr     = (state_reg == ST_L2_RUN) && (fold_reg == FOLD_LAST);
    assign l1_done   = (state_reg == ST_L1_DRAIN) && l1_wr && (wcnt_reg == WCNT_LAST);

    // The raster is shared: it scans accepts in Layer1 and written pixels in Layer2.
    assign ras_clear   = ((state_reg == ST_IDLE) && start) || l1_done;
    assign ras_advance = ((state_reg == ST_L1_RUN) && accept) || l2_wr;

    raster_counter u_raster (
        .clk     (clk),
        .reset   (reset),
        .clear   (ras_clear),
        .advance (ras_advance),
        .x       (ras_x),
        .y       (ras_y),
        .last    (ras_last)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (start)              state_next = ST_L1_RUN;
            ST_L1_RUN:   if (accept && ras_last) state_next = ST_L1_DRAIN;
            ST_L1_DRAIN: if (l1_done)            state_next = ST_L2_RUN;
            ST_L2_RUN:   if (l2_wr && ras_last)  state_next = ST_DONE;
            ST_DONE:                             state_next = ST_IDLE;
            default:                             state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            tok_reg   <= '0;
            wcnt_reg  <= '0;
            fold_reg  <= '0;
        end else begin
            state_reg <= state_next;

            // One token per Layer1 accept; stall bubbles travel down the line as zeros.
            tok_reg[0] <= (state_reg == ST_L1_RUN) && accept;
            for (int i = 1; i < L1_LAT; i++) begin
                tok_reg[i] <= tok_reg[i-1];
            end

            if ((state_reg == ST_IDLE) && start) begin
                wcnt_reg <= '0;
            end else if (l1_wr) begin
                wcnt_reg <= wcnt_reg + 12'd1;
            end

            // Phase 0 waits for the window accept; the remaining phases run unconditionally.
            if (state_reg != ST_L2_RUN) begin
                fold_reg <= '0;
            end else if (l2_wr) begin
                fold_reg <= '0;
            end else if ((fold_reg != 4'd0) || accept) begin
                fold_reg <= fold_reg + 4'd1;
            end
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);
    assign win_x    = ras_x;
    assign win_y    = ras_y;
    assign fold_cnt = fold_reg;
    assign wr_en    = l1_wr || l2_wr;
    assign wr_addr  = (state_reg == ST_L2_RUN) ? {ras_y, ras_x} : wcnt_reg;

    always_comb begin
        layer_sel = LSEL_NONE;
        case (state_reg)
            ST_L1_RUN, ST_L1_DRAIN: layer_sel = LSEL_L1;
            ST_L2_RUN:              layer_sel = LSEL_L2;
            default:                layer_sel = LSEL_NONE;
        endcase
    end

`ifdef LAYER_SCHED_PERF_EN
    logic [19:0] perf_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_reg <= '0;
        end else if ((state_reg == ST_IDLE) && start) begin
            perf_reg <= '0;
        end else if (busy && (perf_reg != 20'hFFFFF)) begin
            perf_reg <= perf_reg + 20'd1;
        end
    end

    assign perf_cycles = perf_reg;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
// Randomized bench for layer_scheduler: an aborted frame, then a full frame with directed and random
// stalls and stray start pulses, every cycle compared with a pixel/phase-level reference model.
module tb_layer_scheduler;

    localparam int LAT      = 4;
    localparam int FLD      = 11;
    localparam int NPIX     = 4096;
    localparam int PERF_MAX = 20'hFFFFF;
    localparam int LIMIT    = 60000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        win_ready;
    logic        busy;
    logic        done;
    logic        win_valid;
    logic [5:0]  win_x;
    logic [5:0]  win_y;
    logic [1:0]  layer_sel;
    logic [3:0]  fold_cnt;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [19:0] perf_cycles;

    always #5 clk = ~clk;

    layer_scheduler #(.L1_LAT(LAT), .FOLD(FLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_x       (win_x),
        .win_y       (win_y),
        .layer_sel   (layer_sel),
        .fold_cnt    (fold_cnt),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .perf_cycles (perf_cycles)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 idle, 1 layer1 streaming, 2 layer1 draining, 3 layer2, 4 done.
    int m_phase;
    int m_acc;
    int m_wcnt;
    int m_l2pix;
    int m_fold;
    int m_perf;
    int cyc;
    int due[$];

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
            if (errors >= 40) begin
                summary();
                $finish;
            end
        end
    endtask

    function automatic bit m_valid();
        return (m_phase == 1) || ((m_phase == 3) && (m_fold == 0));
    endfunction

    function automatic bit m_wr();
        if ((m_phase == 1) || (m_phase == 2))
            return (due.size() > 0) && (due[0] == cyc);
        return (m_phase == 3) && (m_fold == FLD - 1);
    endfunction

    function automatic int m_pix();
        return (m_phase == 3) ? m_l2pix : (m_acc % NPIX);
    endfunction

    function automatic int exp_perf();
`ifdef LAYER_SCHED_PERF_EN
        return m_perf;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_phase = 0; m_acc = 0; m_wcnt = 0; m_l2pix = 0; m_fold = 0; m_perf = 0;
        due.delete();
    endtask

    task automatic check_outputs();
        int pix = m_pix();
        check("busy", busy, m_phase != 0);
        check("done", done, m_phase == 4);
        check("layer_sel", layer_sel, (m_phase == 1 || m_phase == 2) ? 1 : ((m_phase == 3) ? 2 : 0));
        check("win_valid", win_valid, m_valid());
        if (m_valid()) begin
            check("win_x", win_x, pix % 64);
            check("win_y", win_y, pix / 64);
        end
        check("fold_cnt", fold_cnt, (m_phase == 3) ? m_fold : 0);
        check("wr_en", wr_en, m_wr());
        if (m_wr())
            check("wr_addr", wr_addr, (m_phase == 3) ? pix : m_wcnt);
        check("perf_cycles", perf_cycles, exp_perf());
    endtask

    task automatic check_all_zero();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_win_x", win_x, 0);
        check("rst_win_y", win_y, 0);
        check("rst_layer_sel", layer_sel, 0);
        check("rst_fold_cnt", fold_cnt, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_perf_cycles", perf_cycles, 0);
    endtask

    // Advance the model by one clock given the inputs presented for that clock.
    task automatic model_step(input bit rdy, input bit st);
        bit acc      = m_valid() && rdy;
        bit wr       = m_wr();
        bit busy_now = (m_phase != 0);
        int old      = m_phase;
        case (old)
            0: if (st) begin
                m_phase = 1; m_acc = 0; m_wcnt = 0; m_l2pix = 0; m_fold = 0; m_perf = 0;
                due.delete();
            end
            1: if (acc) begin
                due.push_back(cyc + LAT);
                m_acc++;
                if (m_acc == NPIX) m_phase = 2;
            end
            3: begin
                if (m_fold == 0) begin
                    if (acc) m_fold = 1;
                end else if (m_fold == FLD - 1) begin
                    m_fold = 0;
                    m_l2pix++;
                    if (m_l2pix == NPIX) m_phase = 4;
                end else begin
                    m_fold++;
                end
            end
            4: m_phase = 0;
            default: ;
        endcase
        if ((old == 1 || old == 2) && wr) begin
            void'(due.pop_front());
            m_wcnt++;
            if (m_wcnt == NPIX) begin
                m_phase = 3; m_l2pix = 0; m_fold = 0;
            end
        end
        if (busy_now && m_perf < PERF_MAX) m_perf++;
        if (m_phase != old)
            $display("txn cycle=%0d phase %0d -> %0d perf_model=%0d", cyc, old, m_phase, m_perf);
        cyc++;
    endtask

    // One frame; abort_at >= 0 asserts reset asynchronously once Layer1 reaches that pixel.
    task automatic run_frame(input int abort_at);
        int stall = 0;
        bit s1 = 0;
        bit s2 = 0;
        int n = 0;
        bit rdy;
        bit st;
        do begin
            @(negedge clk);
            check_outputs();
            if (abort_at >= 0 && m_phase == 1 && m_acc == abort_at) begin
                #2 reset = 1'b1;
                #1 check_all_zero();
                $display("txn abort by reset at layer1 pixel %0d", abort_at);
                model_reset();
                start = 1'b0;
                win_ready = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    check_outputs();
                end
                reset = 1'b0;
                return;
            end
            rdy = 1'b1;
            if (stall > 0) begin
                rdy = 1'b0;
                stall--;
            end else if (m_phase == 1 && m_acc == 2 * 64 + 10 && !s1) begin
                s1 = 1'b1; stall = 2; rdy = 1'b0;
            end else if (m_phase == 3 && m_fold == 0 && m_l2pix == 5 && !s2) begin
                s2 = 1'b1; stall = 4; rdy = 1'b0;
            end else if (m_phase == 1 && m_acc < 300) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else if (m_phase == 3 && m_l2pix < 40) begin
                rdy = ($urandom_range(0, 2) != 0);
            end
            st = (n == 0) || (m_phase == 1 && n == 50) || (m_phase == 3 && $urandom_range(0, 999) == 0);
            win_ready = rdy;
            start = st;
            model_step(rdy, st);
            n++;
        end while (m_phase != 0 && n < LIMIT);
        check("frame_in_budget", n < LIMIT, 1);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        win_ready = 1'b0;
        cyc = 0;
        model_reset();
        #1 check_all_zero();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        $display("txn reset released");

        run_frame(2000);
        repeat (3) begin
            @(negedge clk);
            check_outputs();
            model_step(1'b1, 1'b0);
        end

        $display("txn full frame start");
        run_frame(-1);
        repeat (5) begin
            @(negedge clk);
            check_outputs();
            win_ready = 1'($urandom_range(0, 1));
            model_step(win_ready, 1'b0);
        end
        $display("txn idle after frame, perf_cycles=%0d", perf_cycles);

        summary();
        $finish;
    end

endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 SHALL have parameter L1_LAT, default 4: Layer1 pipeline latency in cycles, from window accept to result valid.
REQ-002 SHALL have parameter FOLD, default 11: Layer2 cycles per pixel.
REQ-003 SHALL have port clk, input, 1: clock; reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: single-cycle frame start request.
REQ-005 SHALL have port busy, output, 1: high from frame start through DONE.
REQ-006 SHALL have port done, output, 1: one-cycle pulse at frame end.
REQ-007 SHALL have port win_valid, output, 1: window fetch request centred at (win_x, win_y).
REQ-008 SHALL have port win_ready, input, 1: fetch accepted when win_valid and win_ready are both high.
REQ-009 SHALL have ports win_x and win_y, output, 6 each: window centre, x = column, y = row.
REQ-010 SHALL have port layer_sel, output, 2: 00 none, 01 Layer1, 10 Layer2.
REQ-011 SHALL have port fold_cnt, output, 4: Layer2 fold phase, 0..FOLD-1.
REQ-012 SHALL have ports wr_en, output, 1, and wr_addr, output, 12: result write strobe and address {y,x}.
REQ-013 SHALL have port perf_cycles, output, 20: busy-cycle count.

Function
REQ-014 SHALL implement states IDLE, L1_RUN, L1_DRAIN, L2_RUN, DONE.
REQ-015 IDLE->L1_RUN SHALL occur on start=1; busy SHALL rise the next cycle.
REQ-016 start while busy SHALL be ignored, with no state, counter or output effect.
REQ-017 In L1_RUN, win_valid SHALL be 1 every cycle; each accept advances raster x 0..63, then wraps to 0 and increments y.
REQ-018 Acceptance of (63,63) SHALL move L1_RUN->L1_DRAIN; win_valid SHALL be 0 in L1_DRAIN.
REQ-019 An L1_LAT-deep token shift register SHALL delay each accept; wr_en SHALL assert exactly L1_LAT cycles after the accept, with bubbles preserved when win_ready is low.
REQ-020 In Layer1, wr_addr SHALL be a 12-bit write counter, incremented on each wr_en, starting at 0.
REQ-021 L1_DRAIN->L2_RUN SHALL occur the cycle after the 4096th Layer1 write; raster SHALL reset to (0,0) and fold_cnt to 0.
REQ-022 In L2_RUN, win_valid SHALL be 1 only when fold_cnt==0; fold_cnt SHALL hold at 0 until accept, then count 1..FOLD-1 and wrap to 0.
REQ-023 In Layer2, wr_en SHALL be 1 when fold_cnt==FOLD-1, with wr_addr={y,x} of the pixel in flight; the raster SHALL advance on that same cycle.
REQ-024 The Layer2 write at (63,63) SHALL move L2_RUN->DONE; DONE SHALL assert done for one cycle, then go to IDLE with busy=0.
REQ-025 layer_sel SHALL be 01 in L1_RUN/L1_DRAIN, 10 in L2_RUN, and 00 otherwise.
REQ-026 win_x/win_y SHALL hold stable while win_valid=1 and win_ready=0.

Reset
REQ-027 Reset SHALL force IDLE; busy, done, win_valid, wr_en, win_x, win_y, wr_addr, fold_cnt and perf_cycles SHALL be 0; layer_sel SHALL be 00; the token shift register SHALL be cleared.
REQ-028 Reset mid-frame SHALL abort with no done pulse and no further wr_en.

Configuration
REQ-029 With LAYER_SCHED_PERF_EN defined, perf_cycles SHALL clear on frame start and increment each busy cycle, saturating at 2^20-1; it SHALL hold its value after done.
REQ-030 Without LAYER_SCHED_PERF_EN, perf_cycles SHALL be constant 0 and its counter logic SHALL be absent.

Structure
REQ-031 A shared package SHALL hold the state enum, layer_sel codes (LSEL_NONE, LSEL_L1, LSEL_L2), IMG_DIM=64 and PIX_CNT=4096.
REQ-032 A sub-module raster_counter SHALL implement the 6-bit x/y scan with advance input and last-pixel flag, instanced once and cleared between layers.

Verification
REQ-033 Reset, start=1 for one cycle, win_ready tied 1, L1_LAT=4, FOLD=11 -> first wr_en 5 cycles after start with wr_addr=0; done at cycle 1+4096+4+1+4096*11 (±1 per documented boundary), perf_cycles matching.
REQ-034 win_ready low for 3 cycles at pixel (10,2) -> win_x=10, win_y=2 held; wr_en shows a 3-cycle gap; Layer1 writes still total 4096 with contiguous addresses.
REQ-035 Layer2 with win_ready=0 for 5 cycles at fold_cnt=0 -> fold_cnt held at 0; next wr_en exactly 10 cycles after accept.
REQ-036 start pulsed during L2_RUN -> no change in state, counters or done timing.
REQ-037 Reset asserted at Layer1 pixel 2000 -> all outputs 0 asynchronously; no done; a new start completes a full normal frame.
REQ-038 Build without LAYER_SCHED_PERF_EN -> perf_cycles=0 throughout; all other traces identical to the REQ-033 run.
